// File: rtl/segmentos_pkg.sv
// Shared definitions for the 7-segment decoder/encoder pair: FSM states,
// special codes and the 20-entry code -> segment table (bit 0 = segment a).
package segmentos_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONSULTA = 2'd1,
        ENTREGA  = 2'd2
    } estado_t;

    localparam logic [0:4] COD_INVALIDO = 5'b11111;
    localparam logic [0:4] COD_APAGADO  = 5'b10100;
    localparam int         N_TABELA     = 20;

    // Index is the 5-bit code; codes 20..31 drive a blank display.
    localparam logic [0:6] TABELA_SEG [N_TABELA] = '{
        7'b1011011, 7'b1111011, 7'b1010100, 7'b1001110, 7'b0101010,
        7'b1111111, 7'b1101101, 7'b0011111, 7'b1000111, 7'b1100111,
        7'b1011011, 7'b0110111, 7'b0110111, 7'b1111011, 7'b1011111,
        7'b0011100, 7'b0010101, 7'b1110011, 7'b1110000, 7'b1111110
    };

    function automatic logic [0:6] decodifica(input logic [0:4] cod);
        logic [0:6] seg;
        if (cod < 5'd20) begin
            seg = TABELA_SEG[cod];
        end else begin
            seg = 7'b0000000;
        end
        return seg;
    endfunction

endpackage

// File: rtl/tabela_reversa_segmentos.sv
// Combinational reverse lookup: segment pattern -> lowest matching code,
// with flags for patterns shared by several codes or absent from the table.
module tabela_reversa_segmentos
    import segmentos_pkg::*;
(
    input  logic [0:6] seg_in,
    output logic [0:4] codigo,
    output logic       invalido,
    output logic       ambiguo
);

    logic [1:0] acertos_s;
    logic [0:4] primeiro_s;

    // Scan the table in ascending code order; the first hit is the lowest alias.
    always_comb begin
        acertos_s  = 2'd0;
        primeiro_s = COD_INVALIDO;
        for (int i = 0; i < N_TABELA; i++) begin
            if (TABELA_SEG[i] == seg_in) begin
                if (acertos_s == 2'd0) begin
                    primeiro_s = 5'(i);
                end else begin
                    primeiro_s = primeiro_s;
                end
                acertos_s = acertos_s + 2'd1;
            end else begin
                acertos_s = acertos_s;
            end
        end
    end

    // Blank is shared by every unused code, so it reports the lowest unused one.
    always_comb begin
        codigo   = COD_INVALIDO;
        invalido = 1'b0;
        ambiguo  = 1'b0;
        if (acertos_s != 2'd0) begin
            codigo  = primeiro_s;
            ambiguo = (acertos_s > 2'd1);
        end else if (seg_in == 7'b0000000) begin
            codigo  = COD_APAGADO;
            ambiguo = 1'b1;
        end else begin
            codigo   = COD_INVALIDO;
            invalido = 1'b1;
        end
    end

endmodule

// File: rtl/codificador_segmentos.sv
// 7-segment pattern encoder: capture, registered table lookup, then hold the
// result under ready/valid backpressure; counts invalid patterns (saturating).
module codificador_segmentos
    import segmentos_pkg::*;
#(
    parameter int CONT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:6]        seg_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [0:4]        codigo,
    output logic              invalido,
    output logic              ambiguo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CONT_W-1:0] cont_invalidos
);

    estado_t           state_q, state_d;
    logic [0:6]        seg_q, seg_d;
    logic [0:4]        codigo_q, codigo_d;
    logic              invalido_q, invalido_d;
    logic              ambiguo_q, ambiguo_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CONT_W-1:0] cont_q, cont_d;

    logic [0:4]        tab_codigo_s;
    logic              tab_invalido_s;
    logic              tab_ambiguo_s;

    tabela_reversa_segmentos u_tabela (
        .seg_in   (seg_q),
        .codigo   (tab_codigo_s),
        .invalido (tab_invalido_s),
        .ambiguo  (tab_ambiguo_s)
    );

    // Next-state and next-output logic; handshake flags are precomputed so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        codigo_d    = codigo_q;
        invalido_d  = invalido_q;
        ambiguo_d   = ambiguo_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cont_d      = cont_q;
        case (state_q)
            OCIOSO: begin
                if (in_valid && in_ready_q) begin
                    seg_d      = seg_in;
                    state_d    = CONSULTA;
                    in_ready_d = 1'b0;
                end else begin
                    state_d = OCIOSO;
                end
            end
            CONSULTA: begin
                codigo_d    = tab_codigo_s;
                invalido_d  = tab_invalido_s;
                ambiguo_d   = tab_ambiguo_s;
                state_d     = ENTREGA;
                out_valid_d = 1'b1;
                if (tab_invalido_s && (cont_q != {CONT_W{1'b1}})) begin
                    cont_d = cont_q + CONT_W'(1);
                end else begin
                    cont_d = cont_q;
                end
            end
            ENTREGA: begin
                if (out_ready) begin
                    state_d     = OCIOSO;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ENTREGA;
                end
            end
            default: begin
                state_d     = OCIOSO;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OCIOSO;
            seg_q       <= 7'b0000000;
            codigo_q    <= 5'b00000;
            invalido_q  <= 1'b0;
            ambiguo_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cont_q      <= {CONT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            codigo_q    <= codigo_d;
            invalido_q  <= invalido_d;
            ambiguo_q   <= ambiguo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cont_q      <= cont_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign codigo         = codigo_q;
    assign invalido       = invalido_q;
    assign ambiguo        = ambiguo_q;
    assign cont_invalidos = cont_q;

endmodule

// File: tb/tb_codificador_segmentos.sv
// Directed bench for codificador_segmentos: a default-width instance plus a
// CONT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_codificador_segmentos;
    import segmentos_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:6] seg_in;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready, out_valid, invalido, ambiguo;
    logic [0:4] codigo;
    logic [7:0] cont;

    logic       in_ready2, out_valid2, invalido2, ambiguo2;
    logic [0:4] codigo2;
    logic [1:0] cont2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    codificador_segmentos dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .in_valid(in_valid),
        .in_ready(in_ready), .codigo(codigo), .invalido(invalido),
        .ambiguo(ambiguo), .out_valid(out_valid), .out_ready(out_ready),
        .cont_invalidos(cont)
    );

    codificador_segmentos #(.CONT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .in_valid(in_valid),
        .in_ready(in_ready2), .codigo(codigo2), .invalido(invalido2),
        .ambiguo(ambiguo2), .out_valid(out_valid2), .out_ready(out_ready),
        .cont_invalidos(cont2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready held high.
    task automatic txn(input string tag, input logic [0:6] seg, input logic [0:4] cod,
                       input logic inv, input logic amb);
        seg_in   = seg;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_consulta_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_consulta_ir"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_codigo"}, 32'(codigo), 32'(cod));
        chk({tag, "_invalido"}, 32'(invalido), 32'(inv));
        chk({tag, "_ambiguo"}, 32'(ambiguo), 32'(amb));
        step();
        chk({tag, "_idle_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ir"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [0:4] cod;
        logic [0:4] exp_cod;
        logic       exp_amb;

        rst_n     = 1'b0;
        seg_in    = 7'b0000000;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_codigo", 32'(codigo), 32'd0);
        chk("rst_inv", 32'(invalido), 32'd0);
        chk("rst_amb", 32'(ambiguo), 32'd0);
        chk("rst_cont", 32'(cont), 32'd0);
        chk("rst_cont2", 32'(cont2), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ir", 32'(in_ready), 32'd1);

        txn("uni_1010100", 7'b1010100, 5'b00010, 1'b0, 1'b0);
        txn("amb_0110111", 7'b0110111, 5'b01011, 1'b0, 1'b1);
        txn("blank", 7'b0000000, 5'b10100, 1'b0, 1'b1);
        chk("cont_before_inv", 32'(cont), 32'd0);
        txn("inv_0000001", 7'b0000001, 5'b11111, 1'b1, 1'b0);
        chk("cont_after_inv", 32'(cont), 32'd1);
        txn("inv_0000010", 7'b0000010, 5'b11111, 1'b1, 1'b0);
        txn("inv_1000000", 7'b1000000, 5'b11111, 1'b1, 1'b0);
        txn("inv_0100001", 7'b0100001, 5'b11111, 1'b1, 1'b0);
        chk("cont_four", 32'(cont), 32'd4);
        chk("cont2_sat", 32'(cont2), 32'd3);
        txn("inv_0000011", 7'b0000011, 5'b11111, 1'b1, 1'b0);
        chk("cont2_stays_sat", 32'(cont2), 32'd3);
        chk("cont_five", 32'(cont), 32'd5);

        // Backpressure: result must hold and new input must be ignored.
        out_ready = 1'b0;
        seg_in    = 7'b1111111;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("bp_ov", 32'(out_valid), 32'd1);
        chk("bp_codigo", 32'(codigo), 32'b00101);
        seg_in   = 7'b0000110;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_ov", 32'(out_valid), 32'd1);
            chk("bp_hold_codigo", 32'(codigo), 32'b00101);
            chk("bp_hold_inv", 32'(invalido), 32'd0);
            chk("bp_hold_ir", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_done_ov", 32'(out_valid), 32'd0);
        chk("bp_done_ir", 32'(in_ready), 32'd1);
        chk("bp_cont_unchanged", 32'(cont), 32'd5);
        step();
        chk("bp_no_second_ov", 32'(out_valid), 32'd0);

        // Reset while in ENTREGA, together with a would-be handshake.
        out_ready = 1'b0;
        seg_in    = 7'b0000100;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("re_ov", 32'(out_valid), 32'd1);
        chk("re_cont", 32'(cont), 32'd6);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        chk("re_rst_ov", 32'(out_valid), 32'd0);
        chk("re_rst_cont", 32'(cont), 32'd0);
        chk("re_rst_cont2", 32'(cont2), 32'd0);
        chk("re_rst_codigo", 32'(codigo), 32'd0);
        rst_n = 1'b1;
        step();
        chk("re_ir", 32'(in_ready), 32'd1);
        chk("re_idle_ov", 32'(out_valid), 32'd0);

        // Round trip through the decoder table for every code.
        for (int c = 0; c < 32; c++) begin
            cod = 5'(c);
            if (c == 10) begin
                exp_cod = 5'd0;
            end else if (c == 13) begin
                exp_cod = 5'd1;
            end else if (c == 12) begin
                exp_cod = 5'd11;
            end else if (c >= 20) begin
                exp_cod = 5'd20;
            end else begin
                exp_cod = cod;
            end
            exp_amb = (c == 0) || (c == 1) || (c == 10) || (c == 11) ||
                      (c == 12) || (c == 13) || (c >= 20);
            txn($sformatf("rt_%0d", c), decodifica(cod), exp_cod, 1'b0, exp_amb);
        end
        chk("rt_cont", 32'(cont), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
